// File: rtl/mem_data_access_pkg.sv
// Shared MEM-stage types: memory op bundle, access sizes, FSM states.
// Store-side lane helpers live here so other data paths can reuse them.
package mem_data_access_pkg;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       sign;
    logic [1:0] size;
  } mem_op_t;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } mem_state_t;

  function automatic logic [3:0] store_strb(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] s;
    case (size)
      MEM_SZ_B: s = 4'b0001 << off;
      MEM_SZ_H: s = off[1] ? 4'b1100 : 4'b0011;
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] w;
    case (size)
      MEM_SZ_B: w = {4{data[7:0]}};
      MEM_SZ_H: w = {2{data[15:0]}};
      default:  w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_data_access_load_align.sv
// Load lane extraction and sign/zero extension of a raw 32-bit word.
// Purely combinational; shared with the uncached load path.
module load_align
  import mem_data_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = 8'(rdata >> {off, 3'b000});
    h      = 16'(rdata >> {off[1], 4'b0000});
    result = rdata;
    case (size)
      MEM_SZ_B: result = {{24{sign & b[7]}}, b};
      MEM_SZ_H: result = {{16{sign & h[15]}}, h};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_data_access.sv
// MEM-stage data access: registers the EXE op, issues one dcache
// request, aligns load data, stalls while busy, drains flushed loads.
module mem_data_access
  import mem_data_access_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        MEM_Wr,
  input  logic        MEM_Flush,
  input  logic [31:0] EXE_ALUOut,
  input  logic [31:0] EXE_OutB,
  input  mem_op_t     EXE_MemOp,
  input  logic        EXE_ExceptValid,
  output logic        dreq_valid,
  output logic        dreq_wr,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_wstrb,
  output logic [31:0] dreq_wdata,
  input  logic        dreq_ready,
  input  logic        drsp_valid,
  input  logic [31:0] drsp_rdata,
  output logic [31:0] MEM_LoadData,
  output logic        MEM_DataStall
);

  mem_state_t  state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        vld_q, vld_d;
  logic        dpend_q, dpend_d;
  logic        stall, cap, pend_new;
  logic [31:0] aligned;

  load_align u_align (
    .rdata  (drsp_rdata),
    .off    (addr_q[1:0]),
    .size   (op_q.size),
    .sign   (op_q.sign),
    .result (aligned)
  );

  // A store handshake frees the stage in the same cycle.
  assign stall =
    (state_q == ST_REQ && !(dreq_ready && op_q.store)) ||
    (state_q == ST_WAIT) ||
    (state_q == ST_DRAIN && dpend_q);

  assign cap      = MEM_Wr & ~MEM_Flush & ~stall;
  assign pend_new = (EXE_MemOp.load | EXE_MemOp.store)
                  & ~EXE_ExceptValid;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (MEM_Flush) state_d = ST_IDLE;
        else if (cap)  state_d = pend_new ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (MEM_Flush) state_d = ST_IDLE;
        else if (dreq_ready) begin
          if (op_q.store)
            state_d = (cap && pend_new) ? ST_REQ : ST_IDLE;
          else if (op_q.load)
            state_d = ST_WAIT;
          else
            state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (MEM_Flush)       state_d = ST_DRAIN;
        else if (drsp_valid) state_d = ST_DONE;
      end
      ST_DRAIN: begin
        if (drsp_valid)
          state_d = (!MEM_Flush && (dpend_q || (cap && pend_new)))
                  ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    load_d  = load_q;
    dpend_d = 1'b0;
    if (cap) begin
      op_d    = EXE_MemOp;
      addr_d  = EXE_ALUOut;
      wdata_d = store_data(EXE_MemOp.size, EXE_OutB);
      wstrb_d = (pend_new && EXE_MemOp.store)
              ? store_strb(EXE_MemOp.size, EXE_ALUOut[1:0])
              : 4'b0000;
    end
    if (state_q == ST_DRAIN && !drsp_valid && !MEM_Flush)
      dpend_d = dpend_q | (cap & pend_new);
    if (state_q == ST_WAIT && !MEM_Flush && drsp_valid)
      load_d = aligned;
    vld_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      load_q  <= '0;
      vld_q   <= 1'b0;
      dpend_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      load_q  <= load_d;
      vld_q   <= vld_d;
      dpend_q <= dpend_d;
    end
  end

  assign dreq_valid    = vld_q;
  assign dreq_wr       = op_q.store;
  assign dreq_addr     = addr_q;
  assign dreq_size     = op_q.size;
  assign dreq_wstrb    = wstrb_q;
  assign dreq_wdata    = wdata_q;
  assign MEM_LoadData  = load_q;
  assign MEM_DataStall = stall;

endmodule

// File: tb/tb_mem_data_access.sv
// Scoreboard bench for mem_data_access: directed cases plus random
// ops checked against a byte-level reference model.
module tb_mem_data_access;
  import mem_data_access_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, MEM_Wr, MEM_Flush, EXE_ExceptValid;
  logic [31:0] EXE_ALUOut, EXE_OutB;
  mem_op_t     EXE_MemOp;
  logic        dreq_valid, dreq_wr, dreq_ready;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_wstrb;
  logic        drsp_valid;
  logic [31:0] drsp_rdata, MEM_LoadData;
  logic        MEM_DataStall;

  mem_data_access dut (
    .clk(clk), .resetn(resetn),
    .MEM_Wr(MEM_Wr), .MEM_Flush(MEM_Flush),
    .EXE_ALUOut(EXE_ALUOut), .EXE_OutB(EXE_OutB),
    .EXE_MemOp(EXE_MemOp), .EXE_ExceptValid(EXE_ExceptValid),
    .dreq_valid(dreq_valid), .dreq_wr(dreq_wr),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
    .dreq_ready(dreq_ready),
    .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
    .MEM_LoadData(MEM_LoadData), .MEM_DataStall(MEM_DataStall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] last_load;
  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  int hs_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] sz,
                                          input logic [31:0] a);
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < nbytes(sz); i++) s[int'(a[1:0]) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz,
                                            input logic [31:0] d);
    logic [31:0] w;
    for (int j = 0; j < 4; j++)
      w[8*j +: 8] = d[8*(j % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd,
    input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int bits = 8 * nbytes(sz);
    logic [31:0] m;
    logic [31:0] v = rd >> (8 * int'(a[1:0]));
    if (bits == 32) return rd;
    m = (32'd1 << bits) - 32'd1;
    v = v & m;
    if (sg && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  // Monitor: request handshakes and load results against the queues.
  logic chk_ld = 1'b0;
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      if (MEM_DataStall) stall_cnt++;
      if (MEM_Wr) chk("wr_in_stall", {31'd0, MEM_DataStall}, 32'd0);
      if (chk_ld) begin
        chk_ld = 1'b0;
        if (ld_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ld_unexpected: got %h want none", MEM_LoadData);
        end else chk("ld_data", MEM_LoadData, ld_q.pop_front());
      end
      if (drsp_valid) chk_ld = 1'b1;
      if (dreq_valid && dreq_ready) begin
        req_t e;
        hs_cnt++;
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: got %h want none", dreq_addr);
        end else begin
          e = req_q.pop_front();
          chk("req_wr", {31'd0, dreq_wr}, {31'd0, e.wr});
          chk("req_addr", dreq_addr, e.addr);
          chk("req_size", {30'd0, dreq_size}, {30'd0, e.size});
          chk("req_wstrb", {28'd0, dreq_wstrb}, {28'd0, e.wstrb});
          if (e.wr) chk("req_wdata", dreq_wdata, e.wdata);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic sg,
    input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
    input logic exc);
    req_t e;
    MEM_Wr = 1'b1;
    EXE_MemOp = '{load: ld, store: st, sign: sg, size: sz};
    EXE_ALUOut = a;
    EXE_OutB = wd;
    EXE_ExceptValid = exc;
    if ((ld || st) && !exc) begin
      e.wr = st;
      e.addr = a;
      e.size = sz;
      e.wstrb = st ? ref_strb(sz, a) : 4'b0000;
      e.wdata = ref_wdata(sz, wd);
      req_q.push_back(e);
    end
  endtask

  task automatic respond(input logic [31:0] rd, input logic [31:0] exp);
    drsp_valid = 1'b1;
    drsp_rdata = rd;
    ld_q.push_back(exp);
    last_load = exp;
    cyc();
    drsp_valid = 1'b0;
  endtask

  task automatic do_op(input logic ld, input logic st, input logic sg,
    input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rd, input logic exc, input int d, input int k);
    int s0 = stall_cnt;
    set_op(ld, st, sg, sz, a, wd, exc);
    cyc();
    MEM_Wr = 1'b0;
    EXE_ExceptValid = 1'b0;
    if (!((ld || st) && !exc)) begin
      chk("nop_valid", {31'd0, dreq_valid}, 32'd0);
      chk("nop_stall", {31'd0, MEM_DataStall}, 32'd0);
      return;
    end
    repeat (d) cyc();
    dreq_ready = 1'b1;
    cyc();
    dreq_ready = 1'b0;
    if (ld) begin
      repeat (k - 1) cyc();
      respond(rd, ref_load(rd, a, sz, sg));
    end
    chk("op_stall_cycles", stall_cnt - s0, ld ? d + 1 + k : d);
  endtask

  initial begin
    int s0, h0;
    resetn = 1'b0; MEM_Wr = 1'b0; MEM_Flush = 1'b0;
    EXE_ALUOut = '0; EXE_OutB = '0; EXE_MemOp = '0;
    EXE_ExceptValid = 1'b0; dreq_ready = 1'b0;
    drsp_valid = 1'b0; drsp_rdata = '0; last_load = '0;
    repeat (3) cyc();
    resetn = 1'b1;
    chk("rst_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rst_wstrb", {28'd0, dreq_wstrb}, 32'd0);
    chk("rst_load", MEM_LoadData, 32'd0);
    chk("rst_stall", {31'd0, MEM_DataStall}, 32'd0);

    do_op(0, 1, 0, MEM_SZ_B, 32'h8000_0003, 32'h1234_56A5, 0, 0, 0, 1);
    do_op(1, 0, 1, MEM_SZ_H, 32'h1000_0002, 0, 32'h8001_7FFF, 0, 0, 3);
    chk("lh_signed", MEM_LoadData, 32'hFFFF_8001);
    do_op(1, 0, 0, MEM_SZ_B, 32'h1000_0001, 0, 32'h0000_F200, 0, 1, 1);
    chk("lbu", MEM_LoadData, 32'h0000_00F2);
    do_op(1, 0, 0, MEM_SZ_W, 32'h2000_0000, 0, 0, 1, 0, 1);

    // Flush in WAIT, new load captured in DRAIN, stale reply dropped.
    s0 = stall_cnt;
    set_op(1, 0, 0, MEM_SZ_W, 32'h3000_0010, 0, 0);
    cyc(); MEM_Wr = 1'b0; dreq_ready = 1'b1;
    cyc(); dreq_ready = 1'b0; MEM_Flush = 1'b1;
    cyc(); MEM_Flush = 1'b0;
    set_op(1, 0, 0, MEM_SZ_W, 32'h3000_0020, 0, 0);
    cyc(); MEM_Wr = 1'b0;
    respond(32'hDEAD_BEEF, last_load);
    chk("drain_reissue", {31'd0, dreq_valid}, 32'd1);
    chk("drain_addr", dreq_addr, 32'h3000_0020);
    dreq_ready = 1'b1;
    cyc(); dreq_ready = 1'b0;
    respond(32'h0BAD_F00D, 32'h0BAD_F00D);
    chk("drain_stall_cycles", stall_cnt - s0, 5);

    // Back-to-back stores, ready pattern 1,0,1,1.
    s0 = stall_cnt; h0 = hs_cnt;
    set_op(0, 1, 0, MEM_SZ_W, 32'h4000_0000, 32'h1111_1111, 0);
    cyc(); dreq_ready = 1'b1;
    set_op(0, 1, 0, MEM_SZ_W, 32'h4000_0004, 32'h2222_2222, 0);
    cyc(); dreq_ready = 1'b0; MEM_Wr = 1'b0;
    cyc(); dreq_ready = 1'b1;
    set_op(0, 1, 0, MEM_SZ_W, 32'h4000_0008, 32'h3333_3333, 0);
    cyc(); MEM_Wr = 1'b0;
    cyc(); dreq_ready = 1'b0;
    chk("b2b_handshakes", hs_cnt - h0, 3);
    chk("b2b_stall_cycles", stall_cnt - s0, 1);
    chk("b2b_idle", {31'd0, dreq_valid}, 32'd0);

    // Flush while the request is still unaccepted.
    set_op(1, 0, 0, MEM_SZ_W, 32'h5000_0000, 0, 0);
    void'(req_q.pop_back());
    cyc(); MEM_Wr = 1'b0; MEM_Flush = 1'b1;
    cyc(); MEM_Flush = 1'b0;
    chk("req_flush_valid", {31'd0, dreq_valid}, 32'd0);
    chk("req_flush_stall", {31'd0, MEM_DataStall}, 32'd0);

    // Reset while waiting for a load response.
    set_op(1, 0, 0, MEM_SZ_W, 32'h6000_0000, 0, 0);
    cyc(); MEM_Wr = 1'b0; dreq_ready = 1'b1;
    cyc(); dreq_ready = 1'b0; resetn = 1'b0;
    cyc(); resetn = 1'b1; last_load = '0;
    chk("midrst_stall", {31'd0, MEM_DataStall}, 32'd0);
    chk("midrst_valid", {31'd0, dreq_valid}, 32'd0);
    chk("midrst_load", MEM_LoadData, 32'd0);

    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 5);
      logic [1:0] sz = 2'($urandom_range(0, 2));
      logic [31:0] a = $urandom & ~32'(nbytes(sz) - 1);
      logic ld = (kind <= 2) || (kind == 5 && n[0]);
      logic st = (kind == 3) || (kind == 4);
      logic exc = (kind == 5) && n[1];
      do_op(ld, st, 1'($urandom), sz, a, $urandom, $urandom, exc,
            $urandom_range(0, 2), $urandom_range(1, 3));
    end

    repeat (3) cyc();
    chk("req_q_empty", req_q.size(), 0);
    chk("ld_q_empty", ld_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
